adpll_hop_seq: RTL and testbench
================================

// Module: adpll_hop_seq
// PURPOSE
//  Channel-hop and modulation sequencer for the ADPLL controller (adpll_ctr).
//  - Steps through a programmable table of N_CH channel FCWs and drives FCW/adpll_mode.
//  - Waits for channel_lock, with a timeout, on each channel.
//  - Dwells a programmed number of clk cycles per channel.
//  - In TX, emits PRBS9 data_mod symbols every SYM_DIV cycles.
//  - Replaces the ad-hoc lock/TX bit generator used at top level.
// PARAMETERS
//  N_CH     4     number of channel table entries (>=2); AW = $clog2(N_CH)
//  FCW_W    26    FCW width (MHz * 2^14)
//  DWELL_W  16    dwell counter width
//  SYM_DIV  32    clk cycles per modulation symbol (>=2)
//  LOCK_TO  4096  max cycles in WAIT_LOCK before a lock error
// PORTS
//  clk          in   1        32 MHz reference clock
//  rst          in   1        synchronous, active-high reset
//  en           in   1        block enable; low forces IDLE next cycle
//  start        in   1        pulse: begin a hop sequence at entry 0
//  loop         in   1        1: wrap after last entry; 0: return to IDLE
//  tx_en        in   1        1: dwell in TX with modulation; 0: dwell in RX
//  dwell        in   DWELL_W  dwell length in cycles (0 treated as 1)
//  ch_we        in   1        table write strobe
//  ch_addr      in   AW       table write address
//  ch_fcw       in   FCW_W    table write data
//  channel_lock in   1        lock flag from adpll_ctr
//  FCW          out  FCW_W    frequency control word to adpll_ctr
//  adpll_mode   out  2        PD=0, TEST=1, RX=2, TX=3
//  data_mod     out  1        modulation bit to adpll_ctr
//  hop_idx      out  AW       current table index
//  busy         out  1        high in any state other than IDLE
//  lock_err     out  1        sticky; cleared by start or rst
// BEHAVIOUR
//  Reset values:
//  - All outputs 0; adpll_mode=PD; table entries 0; LFSR=9'h1FF; state=IDLE.
//  Table writes:
//  - Accepted only when busy=0 (one write per cycle); ignored when busy=1.
//  FSM (registered outputs, one state step per clk):
//  - IDLE: mode=PD, data_mod=0.
//    - start&en: hop_idx<=0, lock_err<=0, LFSR<=1FF, go TUNE.
//    - start while busy is ignored.
//  - TUNE (1 cycle): FCW<=table[hop_idx], mode<=RX, timeout cnt<=0, go WAIT_LOCK.
//  - WAIT_LOCK:
//    - channel_lock=1: mode<=tx_en?TX:RX, dwell cnt<=0, sym cnt<=0, go DWELL.
//    - cnt==LOCK_TO-1 without lock: lock_err<=1, go NEXT.
//    - If lock arrives in the same cycle as the timeout, lock wins.
//  - DWELL:
//    - dwell cnt increments each cycle.
//    - In TX: when sym cnt==SYM_DIV-1, data_mod<=LFSR[8], LFSR steps
//      (x^9+x^5+1), sym cnt<=0.
//    - In RX: data_mod held 0.
//    - channel_lock falls: lock_err<=1, go NEXT.
//    - Else when dwell cnt==max(dwell,1)-1: go NEXT.
//    - Loss of lock takes priority over dwell expiry.
//  - NEXT (1 cycle): data_mod<=0, mode<=RX.
//    - hop_idx==N_CH-1: loop? (hop_idx<=0, go TUNE) : go IDLE (mode PD).
//    - Else hop_idx+1, go TUNE.
//  tx_en and dwell:
//  - Sampled on WAIT_LOCK->DWELL.
//  - Changes during DWELL take effect on the next hop.
//  en low in any state:
//  - Next cycle IDLE, mode=PD, data_mod=0, busy=0.
//  - FCW, hop_idx and lock_err hold.
//  rst mid-sequence:
//  - Same effect as reset values above; table contents are lost.
//  Lock latency:
//  - First lock-eligible cycle is 2 clks after start (IDLE->TUNE->WAIT_LOCK).
// TESTING
//  Table write: load {2402,2440,2480,2426}*16384, loop=0, tx_en=0, dwell=10, lock tied 1.
//    -> FCW steps through the 4 entries; each hop lasts 13 clks; then IDLE.
//    -> lock_err=0, mode=PD at end.
//  TX modulation: tx_en=1, dwell=320, lock=1.
//    -> 10 data_mod updates per hop, spaced 32 clks apart.
//    -> First 9 bits are 1,1,1,1,1,1,1,1,1 (seed 1FF), then per PRBS9.
//  Timeout: lock held 0, LOCK_TO=16.
//    -> Each entry stays 16 clks in WAIT_LOCK; lock_err=1 after the first entry.
//    -> Sequence still completes.
//  Loss of lock: drop channel_lock 5 clks into DWELL.
//    -> NEXT the following cycle, lock_err=1, data_mod=0.
//  Loop/wrap and abort: loop=1 -> hop_idx 3->0 continues.
//    -> Deassert en -> IDLE in 1 clk, mode=PD.
//    -> start while busy and ch_we while busy both have no effect.
//  Reset mid-DWELL: assert rst for 1 clk -> all outputs 0 next edge, table reads 0.

Source files
------------

// File: rtl/adpll_hop_seq.sv
// Channel-hop / modulation sequencer for adpll_ctr: walks an FCW table, waits for lock
// with a timeout, dwells per channel in RX or TX, and emits PRBS9 symbols while in TX.
module adpll_hop_seq #(
  parameter int N_CH    = 4,
  parameter int FCW_W   = 26,
  parameter int DWELL_W = 16,
  parameter int SYM_DIV = 32,
  parameter int LOCK_TO = 4096,
  parameter int AW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               start,
  input  logic               loop,
  input  logic               tx_en,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               ch_we,
  input  logic [AW-1:0]      ch_addr,
  input  logic [FCW_W-1:0]   ch_fcw,
  input  logic               channel_lock,
  output logic [FCW_W-1:0]   FCW,
  output logic [1:0]         adpll_mode,
  output logic               data_mod,
  output logic [AW-1:0]      hop_idx,
  output logic               busy,
  output logic               lock_err
);
  localparam int TW = (LOCK_TO > 1) ? $clog2(LOCK_TO) : 1;
  localparam int SW = $clog2(SYM_DIV);
  localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TO - 1);
  localparam logic [SW-1:0] SYM_LAST = SW'(SYM_DIV - 1);
  localparam logic [AW-1:0] IDX_LAST = AW'(N_CH - 1);
  localparam logic [1:0] M_PD = 2'd0, M_RX = 2'd2, M_TX = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_TUNE, S_WAIT, S_DWELL, S_NEXT} state_t;
  state_t state, state_nx;

  logic [N_CH-1:0][FCW_W-1:0] tbl;
  logic [TW-1:0]      to_cnt;
  logic [DWELL_W-1:0] dw_cnt, dw_last;
  logic [SW-1:0]      sym_cnt;
  logic               tx_mode;
  logic [8:0]         lfsr;
  logic               last_ch;

  assign busy    = (state != S_IDLE);
  assign last_ch = (hop_idx == IDX_LAST);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_TUNE;
      S_TUNE:  state_nx = S_WAIT;
      // lock is checked before the timeout so a simultaneous lock still wins
      S_WAIT:  if (channel_lock) state_nx = S_DWELL;
               else if (to_cnt == TO_LAST) state_nx = S_NEXT;
      S_DWELL: if (!channel_lock || dw_cnt == dw_last) state_nx = S_NEXT;
      S_NEXT:  state_nx = (last_ch && !loop) ? S_IDLE : S_TUNE;
      default: state_nx = S_IDLE;
    endcase
    if (!en) state_nx = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      tbl        <= '0;
      to_cnt     <= '0;
      dw_cnt     <= '0;
      dw_last    <= '0;
      sym_cnt    <= '0;
      tx_mode    <= 1'b0;
      lfsr       <= 9'h1FF;
      FCW        <= '0;
      adpll_mode <= M_PD;
      data_mod   <= 1'b0;
      hop_idx    <= '0;
      lock_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (ch_we && state == S_IDLE) tbl[ch_addr] <= ch_fcw;
      if (!en) begin
        adpll_mode <= M_PD;
        data_mod   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            adpll_mode <= M_PD;
            data_mod   <= 1'b0;
            if (start) begin
              hop_idx  <= '0;
              lock_err <= 1'b0;
              lfsr     <= 9'h1FF;
            end
          end
          S_TUNE: begin
            FCW        <= tbl[hop_idx];
            adpll_mode <= M_RX;
            to_cnt     <= '0;
          end
          S_WAIT: begin
            if (channel_lock) begin
              // dwell length and direction are frozen for the whole hop
              adpll_mode <= tx_en ? M_TX : M_RX;
              tx_mode    <= tx_en;
              dw_last    <= (dwell == '0) ? '0 : dwell - 1'b1;
              dw_cnt     <= '0;
              sym_cnt    <= '0;
            end else begin
              to_cnt <= to_cnt + 1'b1;
              if (to_cnt == TO_LAST) lock_err <= 1'b1;
            end
          end
          S_DWELL: begin
            dw_cnt <= dw_cnt + 1'b1;
            if (!channel_lock) begin
              lock_err <= 1'b1;
              data_mod <= 1'b0;
            end else if (tx_mode) begin
              if (sym_cnt == SYM_LAST) begin
                data_mod <= lfsr[8];
                lfsr     <= {lfsr[7:0], lfsr[8] ^ lfsr[4]};
                sym_cnt  <= '0;
              end else begin
                sym_cnt <= sym_cnt + 1'b1;
              end
            end else begin
              data_mod <= 1'b0;
            end
          end
          S_NEXT: begin
            data_mod <= 1'b0;
            if (last_ch) begin
              adpll_mode <= loop ? M_RX : M_PD;
              if (loop) hop_idx <= '0;
            end else begin
              adpll_mode <= M_RX;
              hop_idx    <= hop_idx + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_adpll_hop_seq.sv
// Self-checking bench for adpll_hop_seq: expected timelines come from the hop/dwell arithmetic
// and a PRBS9 bit recurrence, not from the sequencer's internal state.
module tb_adpll_hop_seq;
  localparam int N_CH = 4, FCW_W = 26, DWELL_W = 16, SYM_DIV = 32, LOCK_TO = 16, AW = 2;

  logic clk = 1'b0;
  logic rst, en, start, loop, tx_en, ch_we, channel_lock;
  logic [DWELL_W-1:0] dwell;
  logic [AW-1:0]      ch_addr;
  logic [FCW_W-1:0]   ch_fcw;
  logic [FCW_W-1:0]   FCW;
  logic [1:0]         adpll_mode;
  logic               data_mod, busy, lock_err;
  logic [AW-1:0]      hop_idx;

  int total = 0, bad = 0;
  logic [FCW_W-1:0] tbl [N_CH];
  bit prbs [0:63];

  adpll_hop_seq #(.N_CH(N_CH), .FCW_W(FCW_W), .DWELL_W(DWELL_W), .SYM_DIV(SYM_DIV),
                  .LOCK_TO(LOCK_TO), .AW(AW)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .loop(loop), .tx_en(tx_en),
    .dwell(dwell), .ch_we(ch_we), .ch_addr(ch_addr), .ch_fcw(ch_fcw),
    .channel_lock(channel_lock), .FCW(FCW), .adpll_mode(adpll_mode),
    .data_mod(data_mod), .hop_idx(hop_idx), .busy(busy), .lock_err(lock_err));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_tbl(input bit rnd);
    int spec_mhz [4] = '{2402, 2440, 2480, 2426};
    for (int i = 0; i < N_CH; i++) begin
      tbl[i]  = rnd ? (FCW_W'($urandom) | 1) : FCW_W'(spec_mhz[i] * 16384);
      ch_we   = 1'b1;
      ch_addr = AW'(i);
      ch_fcw  = tbl[i];
      tick();
    end
    ch_we = 1'b0;
  endtask

  task automatic abort_seq();
    en = 1'b0;
    tick();
    en = 1'b1;
    channel_lock = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; start = 0; loop = 0; tx_en = 0; dwell = '0;
    ch_we = 0; ch_addr = '0; ch_fcw = '0; channel_lock = 0;
    tick(); tick();
    rst = 1'b0;
    total += 6;
    if (FCW !== '0) begin bad++; $display("FAIL reset_fcw got=%h exp=0", FCW); end
    if (adpll_mode !== 2'd0) begin bad++; $display("FAIL reset_mode got=%0d exp=0", adpll_mode); end
    if (data_mod !== 1'b0) begin bad++; $display("FAIL reset_dm got=%b exp=0", data_mod); end
    if (hop_idx !== '0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", hop_idx); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (lock_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", lock_err); end
  endtask

  // RX hopping, lock always present: each hop is TUNE + 1 lock cycle + dwell + NEXT
  task automatic test_hop(input int dw, input bit rnd);
    int p = ((dw == 0) ? 1 : dw) + 3;
    load_tbl(rnd);
    loop = 0; tx_en = 0; dwell = DWELL_W'(dw); channel_lock = 1;
    start = 1; tick(); start = 0;
    for (int k = 1; k <= 4 * p; k++) begin
      tick();
      if (k % p == 1 && k / p < 4) begin
        total += 2;
        if (FCW !== tbl[k / p]) begin bad++; $display("FAIL hop_fcw dw=%0d k=%0d got=%h exp=%h", dw, k, FCW, tbl[k / p]); end
        if (hop_idx !== AW'(k / p)) begin bad++; $display("FAIL hop_idx dw=%0d k=%0d got=%0d exp=%0d", dw, k, hop_idx, k / p); end
      end
      if (k % p == 2 && k < 4 * p) begin
        total++;
        if (adpll_mode !== 2'd2) begin bad++; $display("FAIL hop_mode_rx k=%0d got=%0d exp=2", k, adpll_mode); end
      end
      if (k == 4 * p - 1) begin
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL hop_busy_end k=%0d got=%b exp=1", k, busy); end
      end
    end
    total += 4;
    if (busy !== 1'b0) begin bad++; $display("FAIL hop_idle dw=%0d got=%b exp=0", dw, busy); end
    if (adpll_mode !== 2'd0) begin bad++; $display("FAIL hop_pd got=%0d exp=0", adpll_mode); end
    if (lock_err !== 1'b0) begin bad++; $display("FAIL hop_err got=%b exp=0", lock_err); end
    if (data_mod !== 1'b0) begin bad++; $display("FAIL hop_dm got=%b exp=0", data_mod); end
  endtask

  // TX: one PRBS9 symbol per SYM_DIV dwell cycles, sequence continuing across hops
  task automatic test_tx_mod();
    int p = 320 + 3;
    bit e;
    for (int n = 0; n < 64; n++) prbs[n] = (n < 9) ? 1'b1 : (prbs[n - 9] ^ prbs[n - 5]);
    load_tbl(1);
    loop = 0; tx_en = 1; dwell = DWELL_W'(320); channel_lock = 1;
    start = 1; tick(); start = 0;
    for (int k = 1; k <= 4 * p; k++) begin
      int h, o, m;
      tick();
      h = k / p; o = k % p;
      if (h >= 4) continue;
      if (o == 2) begin
        total++;
        if (adpll_mode !== 2'd3) begin bad++; $display("FAIL tx_mode k=%0d got=%0d exp=3", k, adpll_mode); end
      end
      if (o == 0) begin
        total++;
        if (data_mod !== 1'b0) begin bad++; $display("FAIL tx_dm_clear k=%0d got=%b exp=0", k, data_mod); end
      end
      if (o >= 33 && (o - 33) % 32 == 0 && (o - 33) / 32 <= 9) begin
        m = (o - 33) / 32;
        e = (m == 0) ? 1'b0 : prbs[10 * h + m - 1];
        total++;
        if (data_mod !== e) begin bad++; $display("FAIL tx_hold k=%0d got=%b exp=%b", k, data_mod, e); end
      end
      if (o >= 34 && (o - 34) % 32 == 0 && (o - 34) / 32 <= 9) begin
        m = (o - 34) / 32;
        e = prbs[10 * h + m];
        total++;
        if (data_mod !== e) begin bad++; $display("FAIL tx_sym k=%0d h=%0d m=%0d got=%b exp=%b", k, h, m, data_mod, e); end
      end
    end
    total += 2;
    if (busy !== 1'b0) begin bad++; $display("FAIL tx_idle got=%b exp=0", busy); end
    if (data_mod !== 1'b0) begin bad++; $display("FAIL tx_end_dm got=%b exp=0", data_mod); end
    tx_en = 0;
  endtask

  // No lock: each hop is TUNE + LOCK_TO wait cycles + NEXT
  task automatic test_timeout();
    int p = LOCK_TO + 2;
    load_tbl(1);
    loop = 0; tx_en = 0; dwell = DWELL_W'(5); channel_lock = 0;
    start = 1; tick(); start = 0;
    for (int k = 1; k <= 4 * p; k++) begin
      tick();
      if (k == LOCK_TO || k == LOCK_TO + 1) begin
        total++;
        if (lock_err !== (k == LOCK_TO + 1)) begin bad++; $display("FAIL to_err k=%0d got=%b exp=%b", k, lock_err, k == LOCK_TO + 1); end
      end
      if (k % p == 1 && k / p < 4) begin
        total++;
        if (FCW !== tbl[k / p]) begin bad++; $display("FAIL to_fcw k=%0d got=%h exp=%h", k, FCW, tbl[k / p]); end
      end
      if (k == 4 * p - 1) begin
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL to_busy k=%0d got=%b exp=1", k, busy); end
      end
    end
    total += 3;
    if (busy !== 1'b0) begin bad++; $display("FAIL to_idle got=%b exp=0", busy); end
    if (lock_err !== 1'b1) begin bad++; $display("FAIL to_err_end got=%b exp=1", lock_err); end
    if (adpll_mode !== 2'd0) begin bad++; $display("FAIL to_pd got=%0d exp=0", adpll_mode); end
  endtask

  task automatic test_lock_at_timeout();
    loop = 0; tx_en = 1; dwell = DWELL_W'(50); channel_lock = 0;
    start = 1; tick(); start = 0;
    total++;
    if (lock_err !== 1'b0) begin bad++; $display("FAIL start_clears_err got=%b exp=0", lock_err); end
    for (int k = 1; k <= LOCK_TO + 1; k++) begin
      tick();
      if (k == LOCK_TO) channel_lock = 1;
    end
    total += 2;
    if (adpll_mode !== 2'd3) begin bad++; $display("FAIL lat_mode got=%0d exp=3", adpll_mode); end
    if (lock_err !== 1'b0) begin bad++; $display("FAIL lat_err got=%b exp=0", lock_err); end
    abort_seq();
    tx_en = 0;
  endtask

  task automatic test_lock_loss(input int d);
    loop = 0; tx_en = 1; dwell = DWELL_W'(1000); channel_lock = 1;
    start = 1; tick(); start = 0;
    for (int k = 1; k <= 2 + d; k++) tick();
    if (d >= 32) begin
      total++;
      if (data_mod !== 1'b1) begin bad++; $display("FAIL ll_dm_before d=%0d got=%b exp=1", d, data_mod); end
    end
    channel_lock = 0;
    tick();
    total += 3;
    if (lock_err !== 1'b1) begin bad++; $display("FAIL ll_err d=%0d got=%b exp=1", d, lock_err); end
    if (data_mod !== 1'b0) begin bad++; $display("FAIL ll_dm d=%0d got=%b exp=0", d, data_mod); end
    if (busy !== 1'b1) begin bad++; $display("FAIL ll_busy d=%0d got=%b exp=1", d, busy); end
    tick();
    total += 2;
    if (hop_idx !== AW'(1)) begin bad++; $display("FAIL ll_next_idx d=%0d got=%0d exp=1", d, hop_idx); end
    if (adpll_mode !== 2'd2) begin bad++; $display("FAIL ll_next_mode d=%0d got=%0d exp=2", d, adpll_mode); end
    abort_seq();
    tx_en = 0;
  endtask

  task automatic test_loop_abort();
    int dw = $urandom_range(1, 5);
    int p = dw + 3;
    load_tbl(1);
    loop = 1; tx_en = 0; dwell = DWELL_W'(dw); channel_lock = 1;
    start = 1; tick(); start = 0;
    for (int k = 1; k <= 4 * p + 1; k++) begin
      tick();
      start = 0; ch_we = 0;
      if (k == p + 1) begin
        start = 1; ch_we = 1; ch_addr = '0; ch_fcw = ~tbl[0];
      end
      if (k == 2 * p + 1 || k == 3 * p + 1) begin
        total++;
        if (hop_idx !== AW'(k / p)) begin bad++; $display("FAIL busy_start k=%0d got=%0d exp=%0d", k, hop_idx, k / p); end
      end
    end
    total += 3;
    if (hop_idx !== '0) begin bad++; $display("FAIL wrap_idx got=%0d exp=0", hop_idx); end
    if (FCW !== tbl[0]) begin bad++; $display("FAIL busy_write got=%h exp=%h", FCW, tbl[0]); end
    if (busy !== 1'b1) begin bad++; $display("FAIL wrap_busy got=%b exp=1", busy); end
    en = 0; tick();
    total += 5;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    if (adpll_mode !== 2'd0) begin bad++; $display("FAIL abort_mode got=%0d exp=0", adpll_mode); end
    if (data_mod !== 1'b0) begin bad++; $display("FAIL abort_dm got=%b exp=0", data_mod); end
    if (hop_idx !== '0) begin bad++; $display("FAIL abort_idx got=%0d exp=0", hop_idx); end
    if (FCW !== tbl[0]) begin bad++; $display("FAIL abort_fcw got=%h exp=%h", FCW, tbl[0]); end
    en = 1; loop = 0;
  endtask

  task automatic test_reset_mid();
    logic [FCW_W-1:0] e1;
    load_tbl(1);
    loop = 0; tx_en = 1; dwell = DWELL_W'(200); channel_lock = 1;
    start = 1; tick(); start = 0;
    for (int k = 1; k <= 40; k++) tick();
    rst = 1; tick(); rst = 0;
    total += 6;
    if (FCW !== '0) begin bad++; $display("FAIL rm_fcw got=%h exp=0", FCW); end
    if (adpll_mode !== 2'd0) begin bad++; $display("FAIL rm_mode got=%0d exp=0", adpll_mode); end
    if (data_mod !== 1'b0) begin bad++; $display("FAIL rm_dm got=%b exp=0", data_mod); end
    if (hop_idx !== '0) begin bad++; $display("FAIL rm_idx got=%0d exp=0", hop_idx); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b exp=0", busy); end
    if (lock_err !== 1'b0) begin bad++; $display("FAIL rm_err got=%b exp=0", lock_err); end
    e1 = FCW_W'($urandom) | 1;
    ch_we = 1; ch_addr = AW'(1); ch_fcw = e1; tick(); ch_we = 0;
    tx_en = 0; dwell = DWELL_W'(2);
    start = 1; tick(); start = 0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 6) begin
        total++;
        if (FCW !== e1) begin bad++; $display("FAIL rm_entry1 got=%h exp=%h", FCW, e1); end
      end
      if (k == 11) begin
        total++;
        if (FCW !== '0) begin bad++; $display("FAIL rm_entry2_cleared got=%h exp=0", FCW); end
      end
    end
    abort_seq();
  endtask

  initial begin
    test_reset();
    test_hop(10, 0);
    test_hop(0, 1);
    test_hop($urandom_range(1, 12), 1);
    test_tx_mod();
    test_timeout();
    test_lock_at_timeout();
    test_lock_loss(5);
    test_lock_loss($urandom_range(32, 60));
    test_loop_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
